// File: rtl/pwm_capture.sv
// pwm_capture: per-cycle period/high-time measurement of an async PWM line; valid 2 clk after the synchronised rise (+FILTER_LEN with PWM_CAPTURE_FILTER_EN).
// No backpressure: valid is a single-cycle pulse and results hold until the next capture or timeout.
module pwm_capture #(
  parameter int DATA_WIDTH = 7,
  parameter int CNT_WIDTH  = 16,
  parameter int NOM_PERIOD = 100,
  parameter int TIMEOUT    = 1000,
  parameter int FILTER_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  pwm_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]  period_out,
  output logic                  valid,
  output logic                  period_err,
  output logic                  stuck
);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] DUTY_MAX = CNT_WIDTH'((64'd1 << DATA_WIDTH) - 64'd1);
  localparam logic [CNT_WIDTH-1:0] NOM_CNT  = CNT_WIDTH'(NOM_PERIOD);
  localparam logic [CNT_WIDTH-1:0] TO_CNT   = CNT_WIDTH'(TIMEOUT);

  if (NOM_PERIOD >= TIMEOUT || FILTER_LEN < 1) begin : g_bad_cfg
    $error("pwm_capture: illegal parameter combination");
  end

  function automatic logic [DATA_WIDTH-1:0] sat_duty(input logic [CNT_WIDTH-1:0] v);
    return (v > DUTY_MAX) ? DATA_WIDTH'(DUTY_MAX) : DATA_WIDTH'(v);
  endfunction

  logic s1_q, s2_q, s3_q;
  logic lvl, rise;

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic          f_q, f_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;

  // f follows s2 only once s2 has disagreed for FILTER_LEN cycles in a row
  always_comb begin
    f_d       = f_q;
    flt_cnt_d = '0;
    if (s2_q != f_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) f_d = s2_q;
      else flt_cnt_d = flt_cnt_q + FW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q       <= 1'b0;
      flt_cnt_q <= '0;
    end else begin
      f_q       <= f_d;
      flt_cnt_q <= flt_cnt_d;
    end
  end

  assign lvl = f_q;
`else
  assign lvl = s2_q;
`endif

  assign rise = lvl & ~s3_q;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    period_cnt_q, period_cnt_d;
  logic [CNT_WIDTH-1:0]    high_cnt_q, high_cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CNT_WIDTH-1:0]    period_q, period_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic                    stuck_q, stuck_d;

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    data_d       = data_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    err_d        = err_q;
    stuck_d      = stuck_q;
    if (!enable) begin
      state_d      = IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = ARM;
          period_cnt_d = '0;
          high_cnt_d   = '0;
        end
        ARM: begin
          if (rise) begin
            period_cnt_d = CNT_WIDTH'(1);
            high_cnt_d   = CNT_WIDTH'(1);
            state_d      = RUN;
          end
        end
        RUN: begin
          // a rise always wins over a coincident timeout
          if (rise) begin
            period_d     = period_cnt_q;
            data_d       = sat_duty(high_cnt_q);
            err_d        = (period_cnt_q != NOM_CNT);
            stuck_d      = 1'b0;
            valid_d      = 1'b1;
            period_cnt_d = CNT_WIDTH'(1);
            high_cnt_d   = CNT_WIDTH'(1);
          end else if (period_cnt_q == TO_CNT) begin
            period_d     = TO_CNT;
            data_d       = lvl ? sat_duty(NOM_CNT) : '0;
            err_d        = 1'b1;
            stuck_d      = 1'b1;
            valid_d      = 1'b1;
            period_cnt_d = '0;
            high_cnt_d   = '0;
            state_d      = ARM;
          end else begin
            if (period_cnt_q != CNT_MAX) period_cnt_d = period_cnt_q + CNT_WIDTH'(1);
            if (lvl && high_cnt_q != CNT_MAX) high_cnt_d = high_cnt_q + CNT_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      state_q      <= IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      data_q       <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      s1_q         <= pwm_in;
      s2_q         <= s1_q;
      s3_q         <= lvl;
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      data_q       <= data_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      stuck_q      <= stuck_d;
    end
  end

  assign data_out   = data_q;
  assign period_out = period_q;
  assign valid      = valid_q;
  assign period_err = err_q;
  assign stuck      = stuck_q;

endmodule
